// File: rtl/spi_regbank_pkg.sv
// spi_regbank_pkg: fast-command codes, status bit positions and controller states.
package spi_regbank_pkg;
    localparam logic [5:0] FC_NOP       = 6'h00;
    localparam logic [5:0] FC_CLEAR_ALL = 6'h01;
    localparam logic [5:0] FC_CLR_FLAGS = 6'h02;

    localparam int STAT_BUSY = 7;
    localparam int STAT_IRQ  = 6;
    localparam int STAT_ERR  = 5;
    localparam int STAT_DROP = 4;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;
endpackage

// File: rtl/spi_regbank_ctrl.sv
// spi_regbank_ctrl: config register bank shared by SPI host and core port,
// with fast-command decode (clear-all sweep, flag clear) and SPI status byte.
module spi_regbank_ctrl
    import spi_regbank_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int REG_W = 8,
    parameter logic [2**ADDR_W-1:0] RO_MASK = '0
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [ADDR_W-1:0]             spi_addr,
    input  logic [REG_W-1:0]              spi_wdata,
    input  logic                          spi_wvld,
    output logic [REG_W-1:0]              spi_rdata,
    input  logic [5:0]                    fastcmd,
    input  logic                          fastcmd_vld,
    output logic [7:0]                    status,
    input  logic                          core_req,
    input  logic                          core_we,
    input  logic [ADDR_W-1:0]             core_addr,
    input  logic [REG_W-1:0]              core_wdata,
    output logic                          core_gnt,
    output logic [REG_W-1:0]              core_rdata,
    output logic                          core_rvld,
    output logic [(2**ADDR_W)*REG_W-1:0]  cfg_regs,
    output logic                          irq
);
    localparam int NUM_REGS = 2**ADDR_W;

    state_t state, state_nx;
    logic [ADDR_W-1:0] idx;
    logic [REG_W-1:0] regs [NUM_REGS];
    logic irq_q, err_q, drop_q;
    logic [3:0] cnt;
    logic idle, is_clear, is_clr_flags, is_bad, spi_ok, spi_ro, spi_drop, core_rd;

    assign idle         = state == ST_IDLE;
    assign is_clear     = fastcmd_vld && fastcmd == FC_CLEAR_ALL;
    assign is_clr_flags = fastcmd_vld && fastcmd == FC_CLR_FLAGS;
    assign is_bad       = fastcmd_vld && fastcmd > FC_CLR_FLAGS;
    assign spi_ok       = idle && spi_wvld && !RO_MASK[spi_addr];
    assign spi_ro       = idle && spi_wvld && RO_MASK[spi_addr];
    assign spi_drop     = !idle && spi_wvld;
    // SPI cannot stall, so it always wins; the core simply retries next cycle
    assign core_gnt     = core_req && idle && !spi_wvld;
    assign core_rd      = core_gnt && !core_we;

    assign status = {!idle, irq_q, err_q, drop_q, cnt};
    assign irq    = irq_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign cfg_regs[i*REG_W +: REG_W] = regs[i];
    end

    always_comb begin
        state_nx = idle ? (is_clear ? ST_SWEEP : ST_IDLE) : (&idx ? ST_IDLE : ST_SWEEP);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            idx        <= '0;
            spi_rdata  <= '0;
            core_rdata <= '0;
            core_rvld  <= 1'b0;
            irq_q      <= 1'b0;
            err_q      <= 1'b0;
            drop_q     <= 1'b0;
            cnt        <= '0;
        end else begin
            spi_rdata  <= regs[spi_addr];
            core_rdata <= core_rd ? regs[core_addr] : core_rdata;
            core_rvld  <= core_rd;
            // a flag being set in the same cycle as CLR_FLAGS ends up set
            irq_q      <= spi_ok || (irq_q && !is_clr_flags);
            err_q      <= spi_ro || is_bad || (err_q && !is_clr_flags);
            drop_q     <= spi_drop || (drop_q && !is_clr_flags);
            cnt        <= cnt + 4'(spi_ok);
            idx        <= idle ? '0 : idx + ADDR_W'(1);
            if (!idle)
                regs[idx] <= '0;
            else if (spi_ok)
                regs[spi_addr] <= spi_wdata;
            else if (core_gnt && core_we)
                regs[core_addr] <= core_wdata;
        end
    end
endmodule

// File: tb/tb_spi_regbank_ctrl.sv
// tb_spi_regbank_ctrl: directed scenarios plus randomized traffic checked
// against a per-cycle behavioural model of the register bank.
module tb_spi_regbank_ctrl;
    localparam int AW = 3;
    localparam int RW = 8;
    localparam int N  = 8;

    logic clk = 1'b0, nrst = 1'b0;
    logic [AW-1:0] spi_addr = '0, core_addr = '0;
    logic [RW-1:0] spi_wdata = '0, core_wdata = '0;
    logic spi_wvld = 1'b0, fastcmd_vld = 1'b0, core_req = 1'b0, core_we = 1'b0;
    logic [5:0] fastcmd = '0;
    logic [RW-1:0] spi_rdata, core_rdata;
    logic [7:0] status;
    logic core_gnt, core_rvld, irq;
    logic [N*RW-1:0] cfg_regs;

    logic [N-1:0] ro_mask = 8'h01;
    logic [RW-1:0] m_regs [N];
    int m_busy;
    logic m_irq, m_err, m_drop, m_rvld, exp_gnt, got_gnt;
    logic [3:0] m_cnt;
    logic [RW-1:0] m_srd, m_crd;
    int checks = 0, errors = 0;

    spi_regbank_ctrl #(.ADDR_W(AW), .REG_W(RW), .RO_MASK(8'h01)) dut (
        .clk(clk), .nrst(nrst),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wvld(spi_wvld), .spi_rdata(spi_rdata),
        .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld), .status(status),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvld(core_rvld),
        .cfg_regs(cfg_regs), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [N*RW-1:0] m_flat();
        logic [N*RW-1:0] f;
        for (int i = 0; i < N; i++) f[i*RW +: RW] = m_regs[i];
        return f;
    endfunction

    function automatic logic [7:0] m_status();
        return {m_busy != 0, m_irq, m_err, m_drop, m_cnt};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_busy = 0; m_irq = 0; m_err = 0; m_drop = 0; m_cnt = 0;
        m_srd = '0; m_crd = '0; m_rvld = 0;
    endtask

    // Advance one clock: model consumes the inputs present before the edge.
    task automatic tick();
        logic idle;
        logic [RW-1:0] old [N];
        @(negedge clk);
        got_gnt = core_gnt;
        idle = m_busy == 0;
        exp_gnt = core_req && idle && !spi_wvld;
        old = m_regs;
        m_srd = old[spi_addr];
        m_rvld = exp_gnt && !core_we;
        if (m_rvld) m_crd = old[core_addr];
        if (fastcmd_vld && fastcmd == 6'h02) begin m_irq = 0; m_err = 0; m_drop = 0; end
        if (fastcmd_vld && fastcmd > 6'h02) m_err = 1;
        if (!idle) begin
            m_regs[N - m_busy] = '0;
            m_busy--;
            if (spi_wvld) m_drop = 1;
        end else begin
            if (spi_wvld && ro_mask[spi_addr]) m_err = 1;
            else if (spi_wvld) begin m_regs[spi_addr] = spi_wdata; m_irq = 1; m_cnt++; end
            else if (exp_gnt && core_we) m_regs[core_addr] = core_wdata;
            if (fastcmd_vld && fastcmd == 6'h01) m_busy = N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic spi_write(input logic [AW-1:0] a, input logic [RW-1:0] d);
        spi_addr = a; spi_wdata = d; spi_wvld = 1;
        tick();
        spi_wvld = 0;
    endtask

    task automatic send_fc(input logic [5:0] c);
        fastcmd = c; fastcmd_vld = 1;
        tick();
        fastcmd_vld = 0;
    endtask

    task automatic test_reset();
        nrst = 0; model_reset();
        repeat (2) @(posedge clk);
        #1 nrst = 1;
        checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", status); end
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL reset_regs: got %h expected 0", cfg_regs); end
        spi_write(3'd5, 8'h3C);
        spi_write(3'd4, 8'hC3);
        send_fc(6'h01);
        tick(); tick();
        checks++; if (status[7] !== 1'b1) begin errors++; $display("FAIL sweep_busy_pre_reset: got %b expected 1", status[7]); end
        #2 nrst = 0;
        #1;
        checks++; if (status !== 8'h00) begin errors++; $display("FAIL midsweep_reset_status: got %h expected 00", status); end
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL midsweep_reset_regs: got %h expected 0", cfg_regs); end
        checks++; if (spi_rdata !== 8'h00) begin errors++; $display("FAIL midsweep_reset_spi_rdata: got %h expected 00", spi_rdata); end
        checks++; if (core_rvld !== 1'b0 || core_rdata !== 8'h00) begin errors++; $display("FAIL midsweep_reset_core: got rvld=%b data=%h expected 0/00", core_rvld, core_rdata); end
        model_reset();
        @(posedge clk);
        #1 nrst = 1;
        tick();
        checks++; if (status !== 8'h00) begin errors++; $display("FAIL post_reset_idle: got %h expected 00", status); end
    endtask

    task automatic test_spi_write();
        spi_write(3'd3, 8'hA5);
        checks++; if (cfg_regs[3*RW +: RW] !== 8'hA5) begin errors++; $display("FAIL spi_write_reg3: got %h expected a5", cfg_regs[3*RW +: RW]); end
        checks++; if (status !== 8'h41) begin errors++; $display("FAIL spi_write_status: got %h expected 41", status); end
        tick();
        checks++; if (spi_rdata !== 8'hA5) begin errors++; $display("FAIL spi_rdata_reg3: got %h expected a5", spi_rdata); end
        for (int i = 0; i < 16; i++) spi_write(AW'($urandom_range(1, N-1)), RW'($urandom));
        checks++; if (status[3:0] !== 4'd1) begin errors++; $display("FAIL count_wrap: got %0d expected 1", status[3:0]); end
        checks++; if (cfg_regs !== m_flat()) begin errors++; $display("FAIL wrap_regs: got %h expected %h", cfg_regs, m_flat()); end
    endtask

    task automatic test_read_only();
        spi_write(3'd0, 8'hFF);
        checks++; if (cfg_regs[RW-1:0] !== m_regs[0]) begin errors++; $display("FAIL ro_reg0: got %h expected %h", cfg_regs[RW-1:0], m_regs[0]); end
        checks++; if (status[5] !== 1'b1) begin errors++; $display("FAIL ro_err: got %b expected 1", status[5]); end
        checks++; if (status[3:0] !== m_cnt) begin errors++; $display("FAIL ro_count: got %0d expected %0d", status[3:0], m_cnt); end
        send_fc(6'h02);
        checks++; if (status[6:4] !== 3'b000 || irq !== 1'b0) begin errors++; $display("FAIL clr_flags: got %b irq=%b expected 000/0", status[6:4], irq); end
    endtask

    task automatic test_arbitration();
        core_req = 1; core_we = 1; core_addr = 3'd6; core_wdata = 8'h77;
        spi_write(3'd2, 8'h11);
        checks++; if (got_gnt !== 1'b0) begin errors++; $display("FAIL arb_spi_wins: got gnt=%b expected 0", got_gnt); end
        checks++; if (cfg_regs[2*RW +: RW] !== 8'h11) begin errors++; $display("FAIL arb_spi_data: got %h expected 11", cfg_regs[2*RW +: RW]); end
        tick();
        core_req = 0;
        checks++; if (got_gnt !== 1'b1) begin errors++; $display("FAIL arb_core_retry: got gnt=%b expected 1", got_gnt); end
        checks++; if (cfg_regs[6*RW +: RW] !== 8'h77) begin errors++; $display("FAIL core_write: got %h expected 77", cfg_regs[6*RW +: RW]); end
        core_req = 1; core_we = 0; core_addr = 3'd2;
        tick();
        core_req = 0;
        checks++; if (core_rvld !== 1'b1 || core_rdata !== 8'h11) begin errors++; $display("FAIL core_read: got rvld=%b data=%h expected 1/11", core_rvld, core_rdata); end
        tick();
        checks++; if (core_rvld !== 1'b0) begin errors++; $display("FAIL core_rvld_pulse: got %b expected 0", core_rvld); end
    endtask

    task automatic test_clear_all();
        spi_write(3'd7, 8'hE1);
        send_fc(6'h02);
        send_fc(6'h01);
        core_req = 1; core_we = 1; core_addr = 3'd5; core_wdata = 8'h99;
        for (int k = 0; k < N; k++) begin
            checks++; if (status[7] !== 1'b1) begin errors++; $display("FAIL sweep_busy[%0d]: got %b expected 1", k, status[7]); end
            if (k == 3) begin spi_addr = 3'd4; spi_wdata = 8'h5A; spi_wvld = 1; end
            tick();
            spi_wvld = 0;
            checks++; if (got_gnt !== 1'b0) begin errors++; $display("FAIL sweep_gnt[%0d]: got %b expected 0", k, got_gnt); end
        end
        core_req = 0;
        checks++; if (status[7] !== 1'b0) begin errors++; $display("FAIL sweep_end: got busy=%b expected 0", status[7]); end
        checks++; if (status[4] !== 1'b1) begin errors++; $display("FAIL sweep_drop: got %b expected 1", status[4]); end
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL sweep_cleared: got %h expected 0", cfg_regs); end
    endtask

    task automatic test_fastcmds();
        int n;
        int n_exp;
        spi_write(3'd1, 8'h42);
        send_fc(6'h02);
        send_fc(6'h3F);
        checks++; if (status[5] !== 1'b1) begin errors++; $display("FAIL bad_cmd_err: got %b expected 1", status[5]); end
        checks++; if (cfg_regs !== m_flat()) begin errors++; $display("FAIL bad_cmd_regs: got %h expected %h", cfg_regs, m_flat()); end
        spi_write(3'd7, 8'h81);
        send_fc(6'h01);
        tick(); tick();
        send_fc(6'h01);
        n_exp = m_busy;
        n = 0;
        while (status[7] === 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n !== n_exp) begin errors++; $display("FAIL no_restart: got %0d busy cycles expected %0d", n, n_exp); end
        checks++; if (cfg_regs !== '0) begin errors++; $display("FAIL no_restart_regs: got %h expected 0", cfg_regs); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int r;
            spi_wvld = ($urandom_range(0, 3) == 0);
            spi_addr = AW'($urandom); spi_wdata = RW'($urandom);
            core_req = $urandom_range(0, 1); core_we = $urandom_range(0, 1);
            core_addr = AW'($urandom); core_wdata = RW'($urandom);
            fastcmd_vld = ($urandom_range(0, 11) == 0);
            r = $urandom_range(0, 7);
            fastcmd = r == 0 ? 6'h00 : r == 1 ? 6'h01 : r < 4 ? 6'h02 : 6'($urandom);
            tick();
            checks++; if (got_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt@%0d: got %b expected %b", c, got_gnt, exp_gnt); end
            checks++; if (status !== m_status()) begin errors++; $display("FAIL rnd_status@%0d: got %h expected %h", c, status, m_status()); end
            checks++; if (cfg_regs !== m_flat()) begin errors++; $display("FAIL rnd_regs@%0d: got %h expected %h", c, cfg_regs, m_flat()); end
            checks++; if (spi_rdata !== m_srd) begin errors++; $display("FAIL rnd_spi_rdata@%0d: got %h expected %h", c, spi_rdata, m_srd); end
            checks++; if (core_rvld !== m_rvld || (m_rvld && core_rdata !== m_crd)) begin errors++; $display("FAIL rnd_core_read@%0d: got %b/%h expected %b/%h", c, core_rvld, core_rdata, m_rvld, m_crd); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq@%0d: got %b expected %b", c, irq, m_irq); end
        end
        spi_wvld = 0; fastcmd_vld = 0; core_req = 0;
    endtask

    initial begin
        test_reset();
        test_spi_write();
        test_read_only();
        test_arbitration();
        test_clear_all();
        test_fastcmds();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
